dma_dev_stream_adapter: RTL and testbench
=========================================

// Module: dma_dev_stream_adapter
// PURPOSE
// Device-side front end of the DMA controller. Accepts one transfer command at a time (direction, logical start address, word count) and issues the rqst pulse.
// Runs the dev_ack/dma_ack word handshake and bridges the DMA device port to valid/ready streams. Read direction delivers memory data on m_*; write direction takes data for memory from s_*.
// A 2-entry buffer per direction decouples the stream side from the DMA side. A watchdog aborts stalled transfers.
// PARAMETERS
// ADD_LEN    16    physical address / word-count width; start_addr output is ADD_LEN+1 bits (logical byte address)
// DATA_LEN   16    data word width
// TIMEOUT_W  12    watchdog width; abort after 2^TIMEOUT_W-1 cycles with no beat and no end_flag
// PORTS
// clk          in   1            clock
// reset        in   1            asynchronous, active-high
// cmd_valid    in   1            command offered
// cmd_ready    out  1            adapter idle, command accepted when cmd_valid&cmd_ready
// cmd_rd_wr    in   1            1 = read memory -> m_*, 0 = write s_* -> memory
// cmd_addr     in   ADD_LEN+1    logical start address, passed unshifted
// cmd_words    in   ADD_LEN      word count; 0 is legal (empty transfer)
// s_data/s_valid/s_ready  in/in/out  DATA_LEN/1/1   write-data stream in
// m_data/m_valid/m_ready  out/out/in DATA_LEN/1/1   read-data stream out
// num_words    out  ADD_LEN      to DMA, latched cmd_words
// start_addr   out  ADD_LEN+1    to DMA, latched cmd_addr
// rd_wr        out  1            to DMA, latched cmd_rd_wr
// rqst         out  1            to DMA, one-cycle request pulse
// dev_ack      out  1            to DMA, device ready / data valid
// dev_in       out  DATA_LEN     to DMA, write data (buffer head)
// dev_out      in   DATA_LEN     from DMA, read data
// dma_ack      in   1            from DMA, word valid / accepted
// end_flag     in   1            from DMA, transfer finished
// busy         out  1            state != IDLE
// done         out  1            one-cycle pulse on entry to DONE
// err_timeout  out  1            sticky until next accepted command
// beat_cnt     out  ADD_LEN      words transferred in current/last command
// BEHAVIOUR
// Reset, async: state IDLE; all outputs 0 except cmd_ready=1; buffers empty; num_words, start_addr, beat_cnt, watchdog = 0.
// Beat: a rising edge with dev_ack&dma_ack=1 moves exactly one word. Read: captures dev_out into the read buffer. Write: pops the write buffer.
// States:
//  IDLE   cmd_ready=1. On cmd_valid: latch cmd_*, clear beat_cnt, err_timeout, watchdog; go to REQ. Both buffers are flushed on entry.
//  REQ    rqst=1 for exactly this cycle; go to XFER.
//  XFER   Read: dev_ack = (rbuf_cnt<2) & (beat_cnt!=num_words). Write: dev_ack = (wbuf_cnt>0) & (beat_cnt!=num_words).
//         end_flag goes to DRAIN for read, or DONE for write.
//  DRAIN  dev_ack=0. Go to DONE when rbuf_cnt==0 (m_* keeps emptying).
//  DONE   done=1 for one cycle; go to IDLE.
// num_words, start_addr and rd_wr stay stable from the acceptance edge until IDLE is re-entered.
// dev_ack is decoded only from registered state, with no combinational path from dma_ack, end_flag or the stream inputs.
// Buffers: 2-entry FIFOs. A simultaneous push and pop at count 2 is allowed and leaves the count unchanged.
//  m_valid = rbuf_cnt>0, m_data = rbuf head.
//  s_ready = (wbuf_cnt<2) & busy & ~rd_wr & (pushed words < num_words). Never pre-fetch beyond num_words.
// beat_cnt increments per beat and saturates at num_words. A beat that would exceed num_words is not acknowledged (dev_ack=0).
// Watchdog: counts in XFER; cleared on any beat or on entering XFER. At all-ones: set err_timeout, flush both buffers, go to DONE.
// Write end_flag with wbuf_cnt>0: flush the buffer and set err_timeout.
// end_flag in IDLE/REQ/DONE is ignored. dma_ack outside XFER is ignored.
// cmd_words=0: REQ, then XFER, then end_flag, then DONE. No beats; beat_cnt stays 0.
// Latency: cmd accept -> rqst 1 cycle; end_flag -> done 1 cycle (write) or 1 + drain cycles (read). Throughput 1 word/cycle.
// Reset mid-transfer returns to IDLE at once. The DMA controller shares the reset and is reset with it.
// TESTING
// 1 Read, 4 words at addr 0x0200, m_ready=1: start_addr=0x0200 and num_words=4 stable. m_* carries 4 words in DMA order. done 1 cycle after end_flag; beat_cnt=4.
// 2 Read, m_ready=0 until end_flag: at most 2 beats, then dev_ack=0. Raising m_ready drains the buffer and the transfer completes in order with no loss or duplication.
// 3 Write, 3 words 0xA1,0xB2,0xC3 with gappy s_valid: dev_in shows each word while dev_ack=1. Exactly 3 beats; s_ready=0 after the 3rd push. done pulses after end_flag.
// 4 cmd_words=0: rqst pulses, no dev_ack; end_flag -> done; beat_cnt=0, err_timeout=0.
// 5 Stall with no dma_ack or end_flag for 2^TIMEOUT_W-1 cycles: err_timeout=1, buffers empty, done, then IDLE. The next command clears err_timeout.
// 6 Assert reset during a read beat: all outputs return to reset values; a command issued after reset completes normally.

Source files
------------

// File: rtl/dma_dev_stream_adapter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dma_dev_stream_adapter
// Device-side DMA front end: one command at a time, dev_ack/dma_ack word
// handshake bridged to valid/ready streams through 2-entry buffers.
// Revision: 1.0
// ----------------------------------------------------------------------------
module dma_dev_stream_adapter #(
  parameter int ADD_LEN   = 16,
  parameter int DATA_LEN  = 16,
  parameter int TIMEOUT_W = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rd_wr,
  input  logic [ADD_LEN:0]    cmd_addr,
  input  logic [ADD_LEN-1:0]  cmd_words,
  input  logic [DATA_LEN-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATA_LEN-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ADD_LEN-1:0]  num_words,
  output logic [ADD_LEN:0]    start_addr,
  output logic                rd_wr,
  output logic                rqst,
  output logic                dev_ack,
  output logic [DATA_LEN-1:0] dev_in,
  input  logic [DATA_LEN-1:0] dev_out,
  input  logic                dma_ack,
  input  logic                end_flag,
  output logic                busy,
  output logic                done,
  output logic                err_timeout,
  output logic [ADD_LEN-1:0]  beat_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADD_LEN-1:0]   ONE_A = 1;
  localparam logic [TIMEOUT_W-1:0] ONE_W = 1;

  state_t state, state_nx;

  logic [DATA_LEN-1:0]  rbuf [2];
  logic [DATA_LEN-1:0]  wbuf [2];
  logic                 rbuf_rp, wbuf_rp;
  logic [1:0]           rbuf_cnt, wbuf_cnt, rbuf_cnt_nx, wbuf_cnt_nx;
  logic [ADD_LEN-1:0]   push_cnt;
  logic [TIMEOUT_W-1:0] wdog;
  logic accept, beat, rpush, rpop, wpush, wpop, wd_expire, wr_abort, flush;

  assign accept  = cmd_valid & cmd_ready;
  assign beat    = dev_ack & dma_ack;
  assign rpush   = beat & rd_wr;
  assign rpop    = m_valid & m_ready;
  assign wpush   = s_valid & s_ready;
  assign wpop    = beat & ~rd_wr;
  assign m_valid = (rbuf_cnt != 2'd0);
  assign m_data  = rbuf[rbuf_rp];
  assign dev_in  = wbuf[wbuf_rp];
  // Never accept more write words than the command will consume.
  assign s_ready = (wbuf_cnt < 2'd2) & busy & ~rd_wr & (push_cnt < num_words);

  assign rbuf_cnt_nx = rbuf_cnt + {1'b0, rpush} - {1'b0, rpop};
  assign wbuf_cnt_nx = wbuf_cnt + {1'b0, wpush} - {1'b0, wpop};

  assign wd_expire = (state == XFER) & (&wdog) & ~beat & ~end_flag;
  assign wr_abort  = (state == XFER) & end_flag & ~rd_wr & (wbuf_cnt_nx != 2'd0);
  assign flush     = accept | wd_expire | wr_abort | (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rqst      = 1'b0;
    dev_ack   = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = REQ;
      end
      REQ: begin
        rqst     = 1'b1;
        state_nx = XFER;
      end
      XFER: begin
        dev_ack = (rd_wr ? (rbuf_cnt < 2'd2) : (wbuf_cnt != 2'd0)) & (beat_cnt != num_words);
        // A read with nothing left to hand out skips the drain step.
        if (end_flag)       state_nx = (rd_wr && rbuf_cnt_nx != 2'd0) ? DRAIN : DONE;
        else if (wd_expire) state_nx = DONE;
      end
      DRAIN: if (rbuf_cnt == 2'd0) state_nx = DONE;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_words   <= '0;
      start_addr  <= '0;
      rd_wr       <= 1'b0;
      beat_cnt    <= '0;
      err_timeout <= 1'b0;
      wdog        <= '0;
      push_cnt    <= '0;
    end else begin
      if (accept) begin
        num_words   <= cmd_words;
        start_addr  <= cmd_addr;
        rd_wr       <= cmd_rd_wr;
        beat_cnt    <= '0;
        err_timeout <= 1'b0;
        push_cnt    <= '0;
      end else begin
        if (beat && beat_cnt != num_words) beat_cnt <= beat_cnt + ONE_A;
        if (wpush)                         push_cnt <= push_cnt + ONE_A;
        if (wd_expire || wr_abort)         err_timeout <= 1'b1;
      end
      if (state == XFER) wdog <= beat ? '0 : wdog + ONE_W;
      else               wdog <= '0;
    end
  end

  // Write slot is rp+cnt mod 2, which is also the popped slot at count 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf[0]  <= '0;
      rbuf[1]  <= '0;
      rbuf_rp  <= 1'b0;
      rbuf_cnt <= 2'd0;
    end else if (flush) begin
      rbuf_rp  <= 1'b0;
      rbuf_cnt <= 2'd0;
    end else begin
      if (rpush) rbuf[rbuf_rp ^ rbuf_cnt[0]] <= dev_out;
      if (rpop)  rbuf_rp <= ~rbuf_rp;
      rbuf_cnt <= rbuf_cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbuf[0]  <= '0;
      wbuf[1]  <= '0;
      wbuf_rp  <= 1'b0;
      wbuf_cnt <= 2'd0;
    end else if (flush) begin
      wbuf_rp  <= 1'b0;
      wbuf_cnt <= 2'd0;
    end else begin
      if (wpush) wbuf[wbuf_rp ^ wbuf_cnt[0]] <= s_data;
      if (wpop)  wbuf_rp <= ~wbuf_rp;
      wbuf_cnt <= wbuf_cnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_dev_stream_adapter.sv
`default_nettype none
// Bench for dma_dev_stream_adapter: directed read/write/empty/timeout/reset
// scenarios; stream words are checked against a queue by a separate monitor.
module tb_dma_dev_stream_adapter;
  logic        clk, reset;
  logic        cmd_valid, cmd_ready, cmd_rd_wr;
  logic [16:0] cmd_addr, start_addr;
  logic [15:0] cmd_words, num_words, beat_cnt;
  logic [15:0] s_data, m_data, dev_in, dev_out;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic        rd_wr, rqst, dev_ack, dma_ack, end_flag, busy, done, err_timeout;

  int total = 0;
  int bad   = 0;
  int dk;
  logic [15:0] mem [8];
  logic [15:0] rd_exp[$];
  logic [15:0] wr_exp[$];

  dma_dev_stream_adapter #(.ADD_LEN(16), .DATA_LEN(16), .TIMEOUT_W(12)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .num_words(num_words), .start_addr(start_addr), .rd_wr(rd_wr), .rqst(rqst),
    .dev_ack(dev_ack), .dev_in(dev_in), .dev_out(dev_out), .dma_ack(dma_ack),
    .end_flag(end_flag), .busy(busy), .done(done), .err_timeout(err_timeout),
    .beat_cnt(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each word at the cycle it crosses an interface.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        if (rd_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_extra: got=%0h want=none", m_data);
        end else chk("rd_data", {16'h0, m_data}, {16'h0, rd_exp.pop_front()});
      end
      if (dev_ack && dma_ack && !rd_wr) begin
        if (wr_exp.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_extra: got=%0h want=none", dev_in);
        end else chk("wr_data", {16'h0, dev_in}, {16'h0, wr_exp.pop_front()});
      end
    end
  end

  task automatic issue(input logic rd, input logic [16:0] addr, input logic [15:0] n);
    int c;
    c = 0;
    while (!cmd_ready && c < 50) begin tick(); c++; end
    cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = addr; cmd_words = n;
    tick();
    cmd_valid = 1'b0;
    chk("rqst_pulse", {31'h0, rqst}, 32'h1);
    chk("start_addr", {15'h0, start_addr}, {15'h0, addr});
    chk("num_words", {16'h0, num_words}, {16'h0, n});
    chk("rd_wr", {31'h0, rd_wr}, {31'h0, rd});
    dk = 0;
  endtask

  // DMA side: acknowledge whenever the adapter offers, until target beats or budget.
  task automatic dma_run(input int target, input int budget);
    int   c;
    logic a;
    c = 0;
    while (dk < target && c < budget) begin
      a = dev_ack;
      dma_ack = a;
      if (a) dev_out = mem[dk];
      tick();
      if (a) dk++;
      c++;
    end
    dma_ack = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done && c < budget) begin tick(); c++; end
    chk("done_seen", {31'h0, done}, 32'h1);
  endtask

  task automatic pulse_end();
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
  endtask

  logic [15:0] wv [3];
  int          gap [3];
  int          cyc;

  initial begin
    reset = 1'b1; cmd_valid = 0; cmd_rd_wr = 0; cmd_addr = '0; cmd_words = '0;
    s_data = '0; s_valid = 0; m_ready = 0; dev_out = '0; dma_ack = 0; end_flag = 0;
    tick(); tick();
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_outputs", {24'h0, rqst, dev_ack, busy, done, err_timeout, m_valid, s_ready, rd_wr}, 32'h0);
    chk("rst_regs", {beat_cnt, num_words}, 32'h0);
    chk("rst_addr", {15'h0, start_addr}, 32'h0);
    reset = 1'b0;
    tick();

    // 1: read 4 words, sink always ready
    for (int i = 0; i < 4; i++) begin mem[i] = 16'h1001 + 16'(i); rd_exp.push_back(mem[i]); end
    m_ready = 1'b1;
    issue(1'b1, 17'h0200, 16'd4);
    dma_run(4, 20);
    chk("t1_beats", dk, 4);
    chk("t1_devack_off", {31'h0, dev_ack}, 32'h0);
    chk("t1_addr_stable", {15'h0, start_addr, num_words[0]}, {15'h0, 17'h0200, 1'b0});
    pulse_end();
    chk("t1_done", {31'h0, done}, 32'h1);
    chk("t1_beat_cnt", {16'h0, beat_cnt}, 32'd4);
    tick();
    chk("t1_done_once", {30'h0, done, cmd_ready}, 32'h1);
    chk("t1_queue_empty", rd_exp.size(), 0);

    // 2: read 4 words with back-pressure, then a drain phase
    for (int i = 0; i < 4; i++) begin mem[i] = 16'h2201 * 16'(i + 1); rd_exp.push_back(mem[i]); end
    m_ready = 1'b0;
    issue(1'b1, 17'h1000, 16'd4);
    dma_run(4, 8);
    chk("t2_held_beats", dk, 2);
    chk("t2_devack_full", {31'h0, dev_ack}, 32'h0);
    m_ready = 1'b1;
    dma_run(4, 20);
    chk("t2_beats", dk, 4);
    m_ready = 1'b0;
    pulse_end();
    chk("t2_draining", {29'h0, busy, done, dev_ack}, 32'h4);
    m_ready = 1'b1;
    wait_done(10, cyc);
    chk("t2_beat_cnt", {16'h0, beat_cnt}, 32'd4);
    tick();
    chk("t2_queue_empty", rd_exp.size(), 0);

    // 3: write 3 words with gappy source
    wv[0] = 16'h00A1; wv[1] = 16'h00B2; wv[2] = 16'h00C3;
    gap[0] = 2; gap[1] = 0; gap[2] = 3;
    for (int i = 0; i < 3; i++) wr_exp.push_back(wv[i]);
    m_ready = 1'b0;
    issue(1'b0, 17'h0040, 16'd3);
    fork
      begin
        logic r;
        int   c;
        for (int i = 0; i < 3; i++) begin
          repeat (gap[i]) tick();
          s_valid = 1'b1; s_data = wv[i];
          c = 0;
          do begin r = s_ready; tick(); c++; end while (!r && c < 20);
          s_valid = 1'b0;
        end
        chk("t3_sready_off", {31'h0, s_ready}, 32'h0);
      end
      dma_run(3, 40);
    join
    chk("t3_beats", dk, 3);
    pulse_end();
    chk("t3_done", {31'h0, done}, 32'h1);
    chk("t3_beat_cnt_err", {15'h0, beat_cnt, err_timeout}, {15'h0, 16'd3, 1'b0});
    tick();
    chk("t3_queue_empty", wr_exp.size(), 0);

    // 4: empty transfer
    issue(1'b1, 17'h0010, 16'd0);
    tick();
    chk("t4_rqst_once", {31'h0, rqst}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_no_devack", {31'h0, dev_ack}, 32'h0);
      tick();
    end
    pulse_end();
    chk("t4_done", {31'h0, done}, 32'h1);
    chk("t4_cnt_err", {15'h0, beat_cnt, err_timeout}, 32'h0);
    tick();

    // 5: stall after one read beat until the watchdog fires
    mem[0] = 16'h5555;
    m_ready = 1'b0;
    issue(1'b1, 17'h0300, 16'd2);
    dma_run(1, 10);
    chk("t5_beats", dk, 1);
    chk("t5_held_word", {31'h0, m_valid}, 32'h1);
    wait_done(5000, cyc);
    chk("t5_window", {31'h0, (cyc > 4000 && cyc < 4200)}, 32'h1);
    chk("t5_err", {31'h0, err_timeout}, 32'h1);
    chk("t5_flushed", {31'h0, m_valid}, 32'h0);
    tick();
    chk("t5_idle_sticky", {30'h0, cmd_ready, err_timeout}, 32'h3);

    // 6: reset in the middle of a read beat, then a clean read
    for (int i = 0; i < 3; i++) begin mem[i] = 16'h6001 + 16'(i); rd_exp.push_back(mem[i]); end
    m_ready = 1'b1;
    issue(1'b1, 17'h0400, 16'd3);
    chk("t6_err_cleared", {31'h0, err_timeout}, 32'h0);
    dma_run(1, 10);
    chk("t6_devack_on", {31'h0, dev_ack}, 32'h1);
    dma_ack = 1'b1; dev_out = mem[1];
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_flags", {25'h0, cmd_ready, busy, dev_ack, m_valid, rqst, done, err_timeout}, 32'h40);
    chk("t6_rst_regs", {beat_cnt, num_words}, 32'h0);
    chk("t6_rst_addr", {15'h0, start_addr}, 32'h0);
    dma_ack = 1'b0;
    rd_exp.delete();
    tick(); tick();
    reset = 1'b0;
    tick();
    mem[0] = 16'h7001; mem[1] = 16'h7002;
    rd_exp.push_back(mem[0]); rd_exp.push_back(mem[1]);
    issue(1'b1, 17'h0500, 16'd2);
    dma_run(2, 10);
    chk("t6_beats", dk, 2);
    pulse_end();
    chk("t6_done", {31'h0, done}, 32'h1);
    chk("t6_beat_cnt", {16'h0, beat_cnt}, 32'd2);
    tick();
    chk("t6_queue_empty", rd_exp.size(), 0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
